// File: rtl/button_sequence_capture.sv
// Debounces 8 push buttons after pattern playback and records the index of each press.
// Optional capture timeout is built when TIMEOUT_EN is defined.
module button_sequence_capture #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  level,
    input  logic [7:0]  button,
    output logic [47:0] seq_flat,
    output logic [15:0] slot_valid,
    output logic [4:0]  count,
    output logic [7:0]  led_echo,
    output logic        busy,
    output logic        done,
    output logic        timed_out
);

    typedef enum logic [1:0] {StIdle, StArm, StCapture, StDone} state_e;

    localparam logic [7:0] DbLast = 8'(DEBOUNCE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  deb_q, deb_d, deb_prev_q;
    logic [7:0]  db_cnt_q [8];
    logic [7:0]  db_cnt_d [8];
    logic [47:0] seq_q, seq_d;
    logic [15:0] valid_q, valid_d;
    logic [4:0]  count_q, count_d;
    logic [4:0]  target_q, target_d;
    logic        busy_q, busy_d, done_q, done_d;
    logic [7:0]  press;
    logic [2:0]  press_idx;
    logic [4:0]  level_target;
    logic        start_ok;

`ifdef TIMEOUT_EN
    localparam logic [31:0] ToLast = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        to_q, to_d;
`endif

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            deb_d[i]    = deb_q[i];
            db_cnt_d[i] = '0;
            if (button[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Only the lowest simultaneous press is kept.
    always_comb begin
        press     = deb_q & ~deb_prev_q;
        press_idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (press[i]) press_idx = 3'(i);
        end
    end

    always_comb begin
        case (level)
            3'b001:  level_target = 5'd8;
            3'b010:  level_target = 5'd12;
            3'b100:  level_target = 5'd16;
            default: level_target = 5'd0;
        endcase
        start_ok = start && (level_target != 5'd0);
    end

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        valid_d  = valid_q;
        count_d  = count_q;
        target_d = target_q;
`ifdef TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        to_d     = to_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start_ok) begin
                    seq_d    = '0;
                    valid_d  = '0;
                    count_d  = '0;
                    target_d = level_target;
                    state_d  = StArm;
`ifdef TIMEOUT_EN
                    to_d     = 1'b0;
`endif
                end
            end
            StArm: begin
                // Wait out any button still held from playback.
                if (deb_q == 8'd0) begin
                    state_d = StCapture;
`ifdef TIMEOUT_EN
                    to_cnt_d = '0;
`endif
                end
            end
            StCapture: begin
                if (|press) begin
                    seq_d[3 * int'(count_q[3:0]) +: 3] = press_idx;
                    valid_d[count_q[3:0]]              = 1'b1;
                    count_d                            = count_q + 5'd1;
                    if (count_q + 5'd1 == target_q) state_d = StDone;
`ifdef TIMEOUT_EN
                    to_cnt_d = '0;
                end else if (to_cnt_q == ToLast) begin
                    state_d = StDone;
                    to_d    = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 32'd1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StArm) || (state_d == StCapture);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 8; i++) db_cnt_q[i] <= '0;
            seq_q      <= '0;
            valid_q    <= '0;
            count_q    <= '0;
            target_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef TIMEOUT_EN
            to_cnt_q   <= '0;
            to_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int i = 0; i < 8; i++) db_cnt_q[i] <= db_cnt_d[i];
            seq_q      <= seq_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            target_q   <= target_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef TIMEOUT_EN
            to_cnt_q   <= to_cnt_d;
            to_q       <= to_d;
`endif
        end
    end

    assign seq_flat   = seq_q;
    assign slot_valid = valid_q;
    assign count      = count_q;
    assign led_echo   = (state_q == StCapture) ? deb_q : 8'd0;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef TIMEOUT_EN
    assign timed_out  = to_q;
`else
    assign timed_out  = 1'b0;
`endif

endmodule

// File: tb/tb_button_sequence_capture.sv
// Randomized self-checking bench for button_sequence_capture against a press-list model.
module tb_button_sequence_capture;

    localparam int unsigned DB = 4;
    localparam int unsigned TO = 50;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  level;
    logic [7:0]  button;
    logic [47:0] seq_flat;
    logic [15:0] slot_valid;
    logic [4:0]  count;
    logic [7:0]  led_echo;
    logic        busy, done, timed_out;

    int checks = 0;
    int errors = 0;

    // Model: list of recorded button indices and the round's required count.
    int exp_q[$];
    int exp_target = 0;
    bit model_on   = 0;

    always #5 clk = ~clk;

    button_sequence_capture #(
        .DEBOUNCE_CYCLES(DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .level     (level),
        .button    (button),
        .seq_flat  (seq_flat),
        .slot_valid(slot_valid),
        .count     (count),
        .led_echo  (led_echo),
        .busy      (busy),
        .done      (done),
        .timed_out (timed_out)
    );

    function automatic int lowest(input logic [7:0] m);
        for (int i = 0; i < 8; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic logic [47:0] exp_seq();
        logic [47:0] s = '0;
        foreach (exp_q[k]) s[3*k +: 3] = 3'(exp_q[k]);
        return s;
    endfunction

    function automatic logic [15:0] exp_valid();
        logic [15:0] v = '0;
        foreach (exp_q[k]) v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; level = '0; button = '0;
        tick(2);
        rst = 1'b0;
        model_on = 0;
        exp_q.delete();
    endtask

    task automatic start_round(input logic [2:0] lv);
        level = lv; start = 1'b1;
        tick(1);
        start = 1'b0;
        exp_q.delete();
        exp_target = (lv == 3'b001) ? 8 : (lv == 3'b010) ? 12 : 16;
        model_on = 1;
        tick(2);
    endtask

    task automatic press(input logic [7:0] mask, input int hold, input int gap);
        button = mask;
        tick(hold);
        button = '0;
        tick(gap);
        if (model_on && exp_q.size() < exp_target) exp_q.push_back(lowest(mask));
    endtask

    task automatic test_reset();
        logic [2:0] bad [3] = '{3'b000, 3'b011, 3'b111};
        do_reset();
        checks += 7;
        if (seq_flat !== '0) begin errors++; $display("FAIL rst_seq got %0h want 0", seq_flat); end
        if (slot_valid !== '0) begin errors++; $display("FAIL rst_valid got %0h want 0", slot_valid); end
        if (count !== '0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        if (led_echo !== '0) begin errors++; $display("FAIL rst_led got %0h want 0", led_echo); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        if (timed_out !== 1'b0) begin errors++; $display("FAIL rst_to got %b want 0", timed_out); end
        foreach (bad[i]) begin
            level = bad[i]; start = 1'b1;
            tick(1);
            start = 1'b0;
            tick(2);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL bad_level_%0b busy/done got %b%b want 00", bad[i], busy, done);
            end
        end
    endtask

    task automatic test_level1();
        int pat [8] = '{2, 0, 7, 1, 1, 4, 6, 3};
        start_round(3'b001);
        foreach (pat[i]) press(8'(1 << pat[i]), 10, 10);
        checks += 5;
        if (count !== 5'd8) begin errors++; $display("FAIL lvl1_count got %0d want 8", count); end
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL lvl1_done got done=%b busy=%b want 1 0", done, busy);
        end
        if (slot_valid !== 16'h00FF) begin
            errors++; $display("FAIL lvl1_valid got %h want 00ff", slot_valid);
        end
        if (seq_flat !== exp_seq()) begin
            errors++; $display("FAIL lvl1_seq got %h want %h", seq_flat, exp_seq());
        end
        for (int k = 0; k < 8; k++) begin
            if (seq_flat[3*k +: 3] !== 3'(pat[k])) begin
                errors++; $display("FAIL lvl1_slot%0d got %0d want %0d", k, seq_flat[3*k +: 3], pat[k]);
            end
        end
        button = 8'h01;
        tick(10);
        if (led_echo !== 8'h00) begin
            errors++; $display("FAIL done_led got %h want 00", led_echo);
        end
        button = '0;
        tick(10);
        if (count !== 5'd8) begin errors++; $display("FAIL done_ignore got %0d want 8", count); end
    endtask

    task automatic test_latency();
        do_reset();
        start_round(3'b010);
        button = 8'h01;
        for (int i = 1; i <= int'(DB) + 1; i++) begin
            tick(1);
            checks += 2;
            if (led_echo[0] !== (i >= int'(DB))) begin
                errors++; $display("FAIL lat_led edge%0d got %b want %b", i, led_echo[0], i >= int'(DB));
            end
            if (count !== ((i >= int'(DB) + 1) ? 5'd1 : 5'd0)) begin
                errors++; $display("FAIL lat_count edge%0d got %0d", i, count);
            end
        end
        exp_q.push_back(0);
        button = '0;
        tick(10);
        level = 3'b001; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(2);
        checks++;
        if (count !== 5'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL start_in_capture got count=%0d busy=%b want 1 1", count, busy);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        start_round(3'b001);
        repeat (3) begin
            button = 8'h02; tick(2);
            button = 8'h00; tick(2);
        end
        checks++;
        if (count !== 5'd0) begin errors++; $display("FAIL bounce_early got %0d want 0", count); end
        press(8'h02, 10, 10);
        checks += 2;
        if (count !== 5'd1 || slot_valid !== 16'h0001) begin
            errors++; $display("FAIL bounce_count got %0d/%h want 1/0001", count, slot_valid);
        end
        if (seq_flat !== exp_seq()) begin
            errors++; $display("FAIL bounce_seq got %h want %h", seq_flat, exp_seq());
        end
    endtask

    task automatic test_carry();
        do_reset();
        checks++;
        if (count !== 5'd0 || done !== 1'b0) begin
            errors++; $display("FAIL midrun_reset got count=%0d done=%b want 0 0", count, done);
        end
        button = 8'h10;
        tick(10);
        start_round(3'b001);
        tick(10);
        checks += 2;
        if (busy !== 1'b1 || count !== 5'd0) begin
            errors++; $display("FAIL carry_held got busy=%b count=%0d want 1 0", busy, count);
        end
        if (led_echo !== 8'h00) begin errors++; $display("FAIL carry_led got %h want 00", led_echo); end
        button = '0;
        tick(10);
        press(8'h10, 10, 10);
        checks += 2;
        if (count !== 5'd1 || busy !== 1'b1) begin
            errors++; $display("FAIL carry_count got %0d busy=%b want 1 1", count, busy);
        end
        if (seq_flat !== exp_seq()) begin
            errors++; $display("FAIL carry_seq got %h want %h", seq_flat, exp_seq());
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        start_round(3'b010);
        press(8'h28, 10, 10);
        checks++;
        if (count !== 5'd1 || seq_flat[2:0] !== 3'd3) begin
            errors++; $display("FAIL simul got count=%0d slot0=%0d want 1 3", count, seq_flat[2:0]);
        end
        repeat (10) press(8'(1 << $urandom_range(0, 7)), 8, 8);
        checks++;
        if (done !== 1'b0 || count !== 5'd11) begin
            errors++; $display("FAIL simul_11 got done=%b count=%0d want 0 11", done, count);
        end
        press(8'(1 << $urandom_range(0, 7)), 8, 8);
        checks += 2;
        if (done !== 1'b1 || count !== 5'd12) begin
            errors++; $display("FAIL simul_12 got done=%b count=%0d want 1 12", done, count);
        end
        if (seq_flat !== exp_seq() || slot_valid !== exp_valid()) begin
            errors++; $display("FAIL simul_seq got %h/%h want %h/%h",
                               seq_flat, slot_valid, exp_seq(), exp_valid());
        end
    endtask

    task automatic test_random();
        logic [2:0] lvs [3] = '{3'b001, 3'b010, 3'b100};
        for (int r = 0; r < 6; r++) begin
            int n;
            logic [4:0] prev_count;
            start_round(lvs[$urandom_range(0, 2)]);
            checks++;
            if (count !== 5'd0 || slot_valid !== 16'h0000 || seq_flat !== '0) begin
                errors++; $display("FAIL rnd%0d_clear got count=%0d valid=%h", r, count, slot_valid);
            end
            n = exp_target + $urandom_range(0, 3);
            for (int p = 0; p < n; p++) begin
                logic [7:0] m;
                if ($urandom_range(0, 1) == 1) begin
                    button = 8'($urandom_range(1, 255));
                    tick($urandom_range(1, DB - 1));
                    button = '0;
                    tick(DB);
                end
                m = 8'(1 << $urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) m |= 8'(1 << $urandom_range(0, 7));
                press(m, $urandom_range(DB, DB + 6), $urandom_range(DB, DB + 6));
            end
            checks += 4;
            if (count !== 5'(exp_target)) begin
                errors++; $display("FAIL rnd%0d_count got %0d want %0d", r, count, exp_target);
            end
            if (done !== 1'b1 || timed_out !== 1'b0) begin
                errors++; $display("FAIL rnd%0d_done got %b/%b want 1/0", r, done, timed_out);
            end
            if (slot_valid !== exp_valid()) begin
                errors++; $display("FAIL rnd%0d_valid got %h want %h", r, slot_valid, exp_valid());
            end
            if (seq_flat !== exp_seq()) begin
                errors++; $display("FAIL rnd%0d_seq got %h want %h", r, seq_flat, exp_seq());
            end
            prev_count = count;
            level = 3'b110; start = 1'b1;
            tick(1);
            start = 1'b0;
            tick(2);
            checks++;
            if (done !== 1'b1 || count !== prev_count) begin
                errors++; $display("FAIL rnd%0d_badstart got done=%b count=%0d", r, done, count);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        start_round(3'b100);
        repeat (3) press(8'(1 << $urandom_range(0, 7)), 10, 10);
`ifdef TIMEOUT_EN
        begin
            int waited = 0;
            while (done !== 1'b1 && waited < 200) begin
                tick(1);
                waited++;
            end
            checks += 4;
            if (waited != int'(TO + DB + 1) - 20) begin
                errors++; $display("FAIL to_latency got %0d want %0d", waited, int'(TO + DB + 1) - 20);
            end
            if (done !== 1'b1 || timed_out !== 1'b1) begin
                errors++; $display("FAIL to_flags got %b/%b want 1/1", done, timed_out);
            end
            if (count !== 5'd3 || slot_valid !== 16'h0007) begin
                errors++; $display("FAIL to_count got %0d/%h want 3/0007", count, slot_valid);
            end
            if (seq_flat !== exp_seq()) begin
                errors++; $display("FAIL to_seq got %h want %h", seq_flat, exp_seq());
            end
            start_round(3'b001);
            checks++;
            if (timed_out !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL to_restart got to=%b busy=%b want 0 1", timed_out, busy);
            end
        end
`else
        tick(200);
        checks += 2;
        if (done !== 1'b0 || busy !== 1'b1 || timed_out !== 1'b0) begin
            errors++; $display("FAIL no_to got done=%b busy=%b to=%b want 0 1 0", done, busy, timed_out);
        end
        if (count !== 5'd3 || seq_flat !== exp_seq()) begin
            errors++; $display("FAIL no_to_count got %0d want 3", count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_level1();
        test_latency();
        test_bounce();
        test_carry();
        test_simultaneous();
        test_random();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

endmodule
